issue_scoreboard: RTL and testbench

- Decode-stage issue controller for the 5-stage RV32 pipeline.
- Tracks outstanding register writes from instructions past decode, using a per-register pending counter.
- Stalls decode on RAW hazards and on counter saturation (WAW overflow); un-counts squashed instructions on branch flush.
- Sits beside the decode/execute pipeline register and drives its hold and bubble controls.

---
 rtl/issue_scoreboard.sv | 146 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - decode-stage RAW/WAW issue scoreboard with per-register pending counters
module issue_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_regwrite,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    input  logic        flush_rd_valid,
    input  logic [4:0]  flush_rd,
    output logic        stall,
    output logic        issue,
    output logic        bubble,
    output logic        err,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pending-write counters; entry 0 (x0) is held at zero and never consulted.
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];

    // One-hot views of the three counter-update sources.
    logic [NREG-1:0] inc_oh;
    logic [NREG-1:0] wb_oh;
    logic [NREG-1:0] fl_oh;
    logic [NREG-1:0] uf_vec;

    // Per-register arithmetic scratch, two guard bits so +1/-2 never wraps.
    logic [CNT_W+1:0] up_v;
    logic [CNT_W+1:0] down_v;
    logic [CNT_W+1:0] diff_v;

    logic hz_s1;
    logic hz_s2;
    logic hz_d;

    // A source blocks while a write to it is in flight; with a write-through
    // register file the last outstanding write retiring this cycle is enough.
    function automatic logic src_hazard(
        input logic             use_r,
        input logic [4:0]       idx,
        input logic [CNT_W-1:0] c,
        input logic             wbv,
        input logic [4:0]       wbr
    );
        logic busy;
        logic byp;
        busy = use_r && (idx != 5'd0) && (c != '0);
        byp  = (WB_BYPASS != 0) && (c == CNT_ONE) && wbv && (wbr == idx);
        return busy && !byp;
    endfunction

    // Hazard detection and pipeline-register control.
    always_comb begin
        hz_s1  = src_hazard(dec_use_rs1, dec_rs1, cnt[dec_rs1], wb_valid, wb_rd);
        hz_s2  = src_hazard(dec_use_rs2, dec_rs2, cnt[dec_rs2], wb_valid, wb_rd);
        hz_d   = dec_regwrite && (dec_rd != 5'd0) && (cnt[dec_rd] == CNT_MAX);
        stall  = dec_valid && !flush && (hz_s1 || hz_s2 || hz_d);
        issue  = dec_valid && !flush && !stall;
        bubble = flush || stall;
    end

    // Decode each update source into a per-register strobe; x0 is masked off.
    always_comb begin
        inc_oh = '0;
        wb_oh  = '0;
        fl_oh  = '0;
        if (issue && dec_regwrite) begin
            inc_oh[dec_rd] = 1'b1;
        end
        if (wb_valid) begin
            wb_oh[wb_rd] = 1'b1;
        end
        if (flush && flush_rd_valid) begin
            fl_oh[flush_rd] = 1'b1;
        end
        inc_oh[0] = 1'b0;
        wb_oh[0]  = 1'b0;
        fl_oh[0]  = 1'b0;
    end

    // Net counter update: sum all terms, clamp at zero and flag any underflow.
    always_comb begin
        up_v   = '0;
        down_v = '0;
        diff_v = '0;
        uf_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = '0;
        end
        for (int r = 1; r < NREG; r++) begin
            up_v   = {2'b00, cnt[r]} + {{(CNT_W+1){1'b0}}, inc_oh[r]};
            down_v = {{(CNT_W+1){1'b0}}, wb_oh[r]} + {{(CNT_W+1){1'b0}}, fl_oh[r]};
            diff_v = up_v - down_v;
            if (down_v > up_v) begin
                cnt_nxt[r] = '0;
                uf_vec[r]  = 1'b1;
            end else begin
                cnt_nxt[r] = diff_v[CNT_W-1:0];
            end
        end
    end

    // Counter state; reset discards every in-flight write.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt[r] <= '0;
            end else begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (|uf_vec) begin
            err <= 1'b1;
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard against a behavioural model
module tb_issue_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic [4:0]  dec_rd;
    logic        dec_regwrite;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        flush_rd_valid;
    logic [4:0]  flush_rd;
    logic        stall;
    logic        issue;
    logic        bubble;
    logic        err;
    logic [31:0] stall_cycles;

    int          tests = 0;
    int          fails = 0;

    // Behavioural model state.
    int          mcnt [32];
    bit          merr;
    logic [31:0] msc;
    bit          mvalid = 0;

    // Comb outputs seen in the most recent cycle.
    logic        obs_stall;
    logic        obs_issue;
    logic        obs_bubble;

    issue_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_use_rs1    (dec_use_rs1),
        .dec_use_rs2    (dec_use_rs2),
        .dec_rd         (dec_rd),
        .dec_regwrite   (dec_regwrite),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .flush_rd_valid (flush_rd_valid),
        .flush_rd       (flush_rd),
        .stall          (stall),
        .issue          (issue),
        .bubble         (bubble),
        .err            (err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_rd = 0; dec_regwrite = 0; wb_valid = 0; wb_rd = 0;
        flush = 0; flush_rd_valid = 0; flush_rd = 0;
    endtask

    function automatic bit src_busy(input bit use_r, input int idx);
        if (!use_r || idx == 0 || mcnt[idx] == 0) return 0;
        return 1;
    endfunction

    // One clock: check the DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        bit e_stall, e_issue, e_bubble, hzd;
        @(negedge clk);
        hzd      = dec_regwrite && int'(dec_rd) != 0 && mcnt[int'(dec_rd)] == MAXC;
        e_stall  = dec_valid && !flush &&
                   (src_busy(dec_use_rs1, int'(dec_rs1)) || src_busy(dec_use_rs2, int'(dec_rs2)) || hzd);
        e_issue  = dec_valid && !flush && !e_stall;
        e_bubble = flush || e_stall;
        if (mvalid) begin
            chk("stall", longint'(stall), longint'(e_stall));
            chk("issue", longint'(issue), longint'(e_issue));
            chk("bubble", longint'(bubble), longint'(e_bubble));
            chk("err", longint'(err), longint'(merr));
            chk("stall_cycles", longint'(stall_cycles), longint'(msc));
        end
        obs_stall  = stall;
        obs_issue  = issue;
        obs_bubble = bubble;
        if (rst) begin
            for (int r = 0; r < 32; r++) mcnt[r] = 0;
            merr   = 0;
            msc    = 0;
            mvalid = 1;
        end else begin
            for (int r = 1; r < 32; r++) begin
                int n = mcnt[r];
                if (e_issue && dec_regwrite && int'(dec_rd) == r) n++;
                if (wb_valid && int'(wb_rd) == r) n--;
                if (flush && flush_rd_valid && int'(flush_rd) == r) n--;
                if (n < 0) begin
                    n = 0;
                    merr = 1;
                end
                mcnt[r] = n;
            end
            if (e_stall && msc != 32'hFFFF_FFFF) msc = msc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        int q[$];
        for (int r = 1; r < 32; r++) if (mcnt[r] > 0) q.push_back(r);
        if (q.size() > 0 && $urandom_range(0, 9) < 9)
            return 5'(q[$urandom_range(0, q.size() - 1)]);
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        rst            = ($urandom_range(0, 99) == 0);
        dec_valid      = ($urandom_range(0, 9) < 8);
        dec_rs1        = 5'($urandom_range(0, 7));
        dec_rs2        = 5'($urandom_range(0, 7));
        dec_use_rs1    = 1'($urandom_range(0, 1));
        dec_use_rs2    = 1'($urandom_range(0, 1));
        dec_rd         = 5'($urandom_range(0, 7));
        dec_regwrite   = 1'($urandom_range(0, 1));
        wb_valid       = ($urandom_range(0, 2) == 0);
        wb_rd          = pick_reg();
        flush          = ($urandom_range(0, 9) == 0);
        flush_rd_valid = 1'($urandom_range(0, 1));
        flush_rd       = pick_reg();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        chk("reset_err", longint'(err), 0);
        chk("reset_sc", longint'(stall_cycles), 0);
        chk("reset_cnt5", longint'(dut.cnt[5]), 0);

        // ADD x5,x1,x2 on a clean scoreboard
        dec_valid = 1; dec_rs1 = 1; dec_rs2 = 2; dec_use_rs1 = 1; dec_use_rs2 = 1;
        dec_rd = 5; dec_regwrite = 1;
        cycle();
        chk("add_issue", longint'(obs_issue), 1);
        chk("add_stall", longint'(obs_stall), 0);
        chk("add_cnt5", longint'(dut.cnt[5]), 1);
        chk("model_cnt5", longint'(mcnt[5]), 1);

        // RAW on x5 until writeback retires it
        idle();
        dec_valid = 1; dec_rs1 = 5; dec_use_rs1 = 1;
        cycle();
        chk("raw_stall", longint'(obs_stall), 1);
        chk("raw_bubble", longint'(obs_bubble), 1);
        cycle();
        wb_valid = 1; wb_rd = 5;
        cycle();
        chk("raw_wb_stall", longint'(obs_stall), 1);
        wb_valid = 0;
        cycle();
        chk("raw_release", longint'(obs_issue), 1);
        chk("raw_sc", longint'(stall_cycles), 3);
        chk("model_sc", longint'(msc), 3);

        // WAW saturation on x7
        idle();
        dec_valid = 1; dec_rd = 7; dec_regwrite = 1;
        for (int i = 0; i < 3; i++) cycle();
        cycle();
        chk("waw_stall", longint'(obs_stall), 1);
        chk("waw_cnt7", longint'(dut.cnt[7]), 3);
        wb_valid = 1; wb_rd = 7;
        cycle();
        wb_valid = 0;
        cycle();
        chk("waw_issue", longint'(obs_issue), 1);
        chk("waw_cnt7_back", longint'(dut.cnt[7]), 3);
        chk("waw_sc", longint'(stall_cycles), 5);
        idle();
        wb_valid = 1; wb_rd = 7;
        for (int i = 0; i < 3; i++) cycle();

        // Flush squashes an in-flight write to x9
        idle();
        dec_valid = 1; dec_rd = 9; dec_regwrite = 1;
        cycle();
        idle();
        dec_valid = 1; dec_rs1 = 9; dec_use_rs1 = 1;
        flush = 1; flush_rd_valid = 1; flush_rd = 9;
        cycle();
        chk("flush_issue", longint'(obs_issue), 0);
        chk("flush_bubble", longint'(obs_bubble), 1);
        chk("flush_cnt9", longint'(dut.cnt[9]), 0);
        chk("flush_err", longint'(err), 0);

        // Same-cycle issue and writeback on x4; x0 traffic
        idle();
        dec_valid = 1; dec_rd = 4; dec_regwrite = 1;
        cycle();
        wb_valid = 1; wb_rd = 4;
        cycle();
        chk("simul_issue", longint'(obs_issue), 1);
        chk("simul_cnt4", longint'(dut.cnt[4]), 1);
        idle();
        dec_valid = 1; dec_rd = 0; dec_regwrite = 1; dec_rs1 = 0; dec_use_rs1 = 1;
        wb_valid = 1; wb_rd = 0;
        cycle();
        chk("x0_stall", longint'(obs_stall), 0);
        chk("x0_cnt4", longint'(dut.cnt[4]), 1);
        chk("x0_cnt0", longint'(dut.cnt[0]), 0);
        chk("x0_err", longint'(err), 0);
        idle();
        wb_valid = 1; wb_rd = 4;
        cycle();

        // Underflow on x12, sticky until reset
        idle();
        wb_valid = 1; wb_rd = 12;
        cycle();
        chk("uf_err", longint'(err), 1);
        chk("uf_cnt12", longint'(dut.cnt[12]), 0);
        idle();
        dec_valid = 1; dec_rd = 3; dec_regwrite = 1;
        cycle();
        idle();
        wb_valid = 1; wb_rd = 3;
        cycle();
        chk("uf_sticky", longint'(err), 1);
        idle();
        dec_valid = 1; dec_rd = 3; dec_regwrite = 1;
        cycle();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_err", longint'(err), 0);
        chk("rst_sc", longint'(stall_cycles), 0);
        chk("rst_cnt3", longint'(dut.cnt[3]), 0);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
